serial_adder_ctrl: RTL and testbench

Bit-serial N-bit adder controller that time-shares a single 1-bit full-adder cell across all operand bits, LSB first, one bit per clock.
- Accepts operands through a start/ready handshake and sequences the cell with a bit counter and carry register.
- Returns a registered sum/carry-out with a one-cycle done pulse.
- Sits between a requesting datapath and the shared full-adder resource, replacing N ripple cells with one cell plus control.

---
 rtl/serial_adder_pkg.sv | 6 +
 rtl/serial_adder_ctrl_fa_bit.sv | 11 +
 rtl/serial_adder_ctrl.sv | 108 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// Combinational 1-bit full adder: the single cell the controller time-shares.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ ci;
  assign c = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port (a - b via ~b and carry-in 1).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic             carry;
  logic             s, c;
  logic             last;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  fa_bit u_fa (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .ci(carry),
    .s (s),
    .c (c)
  );

  // acc keeps only the upper WIDTH-1 partial bits; the final bit completes the word.
  assign acc_nx = {s, acc};
  assign last   = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN) || (state == DONE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b_ld;
          carry <= c_ld;
          cnt   <= '0;
          acc   <= '0;
        end
        RUN: begin
          carry <= c;
          acc   <= acc_nx[WIDTH-1:1];
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum  <= acc_nx;
            cout <= c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;
  int ndone;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its done pulse; leaves the bench in the done cycle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int n;
    a = ta; b = tb; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // Latency: done exactly WIDTH edges after the accepting edge.
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_busy", busy, 1);
    chk("lat_in_ready", in_ready, 0);
    ndone = 0;
    for (int i = 1; i < W; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("lat_early_done", ndone, 0);
    tick();
    chk("lat_done", done, 1);
    chk("lat_sum", sum, 8'h10);
    chk("lat_cout", cout, 0);
    tick();
    chk("lat_done_pulse", done, 0);
    chk("lat_in_ready_after", in_ready, 1);

    // Back-to-back requests issued as soon as in_ready returns.
    do_op(8'hFF, 8'h01, 1'b0);
    chk("ff01_sum", sum, 8'h00);
    chk("ff01_cout", cout, 1);
    tick();
    chk("b2b_ready", in_ready, 1);
    do_op(8'hFF, 8'hFF, 1'b1);
    chk("ffff1_sum", sum, 8'hFF);
    chk("ffff1_cout", cout, 1);
    tick();
    do_op(8'h80, 8'h80, 1'b0);
    chk("8080_sum", sum, 8'h00);
    chk("8080_cout", cout, 1);
    tick();

    // A start while busy is ignored and not queued; sum holds until completion.
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_sum", sum, 8'h00);
    tick();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        ndone++;
        chk("ign_sum", sum, 8'h07);
        chk("ign_cout", cout, 0);
      end
      tick();
    end
    chk("ign_done_count", ndone, 1);

    // Reset mid-operation aborts cleanly with no done pulse.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_done", done, 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_op(8'h12, 8'h34, 1'b0);
    chk("readd_sum", sum, 8'h46);
    chk("readd_cout", cout, 0);
    tick();

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op(8'h05, 8'h07, 1'b0);
    chk("sub57_sum", sum, 8'hFE);
    chk("sub57_cout", cout, 0);
    tick();
    do_op(8'h07, 8'h05, 1'b0);
    chk("sub75_sum", sum, 8'h02);
    chk("sub75_cout", cout, 1);
    tick();
    sub = 1'b0;
    do_op(8'h07, 8'h05, 1'b1);
    chk("nosub_sum", sum, 8'h0D);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
